// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard controller with long-op scoreboard.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int PEND_W = 4;

  typedef logic [PEND_W-1:0] pend_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for the single long-latency unit.
// The PC (index NREG-1) has no counter and always reads as not busy.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 16,
  parameter int AW       = 4,
  parameter int NSRC     = 3,
  parameter int LONG_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [AW-1:0]     issueDst,
  input  logic [NSRC*AW-1:0] srcD,
  input  logic [NSRC-1:0]   srcVldD,
  input  logic [AW-1:0]     dstD,
  input  logic              wrD,
  output logic [NSRC-1:0]   srcBusy,
  output logic              dstBusy,
  output logic              longBusy
);

  localparam pend_t ISSUE_CNT = pend_t'(LONG_LAT - 1);
  localparam pend_t ZERO      = {PEND_W{1'b0}};
  localparam pend_t ONE       = pend_t'(1);

  pend_t           pend_r [NREG-1];
  logic [NREG-1:0] busyVec_s;

  // Counter update: a fresh issue reloads its entry, every other busy entry counts down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG-1; r++) pend_r[r] <= ZERO;
    end else begin
      for (int r = 0; r < NREG-1; r++) begin
        if (issue && (issueDst == AW'(r))) pend_r[r] <= ISSUE_CNT;
        else if (pend_r[r] != ZERO)        pend_r[r] <= pend_r[r] - ONE;
        else                               pend_r[r] <= ZERO;
      end
    end
  end

  // Flatten counters to a busy bit per register; the PC slot stays zero.
  always_comb begin
    busyVec_s = {NREG{1'b0}};
    for (int r = 0; r < NREG-1; r++) busyVec_s[r] = (pend_r[r] != ZERO);
  end

  // Lookups for the D-stage operands.
  always_comb begin
    srcBusy = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) srcBusy[i] = srcVldD[i] & busyVec_s[srcD[i*AW +: AW]];
    dstBusy  = wrD & busyVec_s[dstD];
    longBusy = |busyVec_s;
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller: forwarding, load/long-use and scoreboard stalls, PC-write flushes.
// Define HZ_PERF_EN to build the saturating stall/flush cycle counters.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int NREG     = 16,
  parameter int AW       = 4,
  parameter int NSRC     = 3,
  parameter int LONG_LAT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NSRC*AW-1:0]  src_d,
  input  logic [NSRC-1:0]     src_vld_d,
  input  logic [AW-1:0]       dst_d,
  input  logic                wr_d,
  input  logic                long_d,
  input  logic                pcsrc_d,
  input  logic [NSRC*AW-1:0]  src_e,
  input  logic [NSRC-1:0]     src_vld_e,
  input  logic [AW-1:0]       dst_e,
  input  logic                wr_e,
  input  logic                load_e,
  input  logic                long_e,
  input  logic                pc_cancel_e,
  input  logic                branch_taken_e,
  input  logic [AW-1:0]       dst_m,
  input  logic                wr_m,
  input  logic [AW-1:0]       dst_w,
  input  logic                wr_w,
  output logic [NSRC*2-1:0]   fwd_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic                long_busy,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
);

  localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

  logic [NSRC-1:0] srcBusy_s;
  logic dstBusy_s, longBusy_s, issue_s, luse_s, sbStall_s, hz_s, pcPend_s;
  logic pcE_r, pcM_r, pcW_r;

  assign issue_s = long_e & wr_e & (dst_e != PC_IDX);

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .NSRC(NSRC), .LONG_LAT(LONG_LAT)
  ) uScoreboard (
    .clk(clk), .reset(reset), .issue(issue_s), .issueDst(dst_e),
    .srcD(src_d), .srcVldD(src_vld_d), .dstD(dst_d), .wrD(wr_d),
    .srcBusy(srcBusy_s), .dstBusy(dstBusy_s), .longBusy(longBusy_s)
  );

  // Forwarding select per E-stage source; M result is younger so it wins over W.
  always_comb begin
    fwd_e = {(2*NSRC){1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (src_vld_e[i] && (src_e[i*AW +: AW] != PC_IDX) && wr_m && (dst_m == src_e[i*AW +: AW]))
        fwd_e[2*i +: 2] = FWD_M;
      else if (src_vld_e[i] && (src_e[i*AW +: AW] != PC_IDX) && wr_w && (dst_w == src_e[i*AW +: AW]))
        fwd_e[2*i +: 2] = FWD_W;
      else
        fwd_e[2*i +: 2] = FWD_RF;
    end
  end

  // A load or long op in E whose destination is read by the D-stage instruction.
  always_comb begin
    luse_s = 1'b0;
    for (int i = 0; i < NSRC; i++) luse_s = luse_s | (src_vld_d[i] & (src_d[i*AW +: AW] == dst_e));
    luse_s = luse_s & (load_e | long_e) & wr_e;
  end

  assign sbStall_s = (|srcBusy_s) | dstBusy_s | (long_d & longBusy_s);
  assign hz_s      = luse_s | sbStall_s;
  assign pcPend_s  = pcsrc_d | pcE_r | pcM_r;

  assign stall_d   = hz_s & ~branch_taken_e;
  assign stall_f   = (hz_s | pcPend_s) & ~branch_taken_e;
  assign flush_e   = hz_s | branch_taken_e;
  assign flush_d   = pcPend_s | pcW_r | branch_taken_e;
  assign long_busy = longBusy_s;

  // Follow a PC-writing instruction down E/M/W; a cancelled one stops at E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcE_r <= 1'b0;
      pcM_r <= 1'b0;
      pcW_r <= 1'b0;
    end else begin
      pcE_r <= pcsrc_d & ~flush_e;
      pcM_r <= pcE_r & ~pc_cancel_e;
      pcW_r <= pcM_r;
    end
  end

`ifdef HZ_PERF_EN
  logic [31:0] stallCnt_r, flushCnt_r;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_r <= 32'd0;
      flushCnt_r <= 32'd0;
    end else begin
      if (stall_d && (stallCnt_r != 32'hFFFF_FFFF)) stallCnt_r <= stallCnt_r + 32'd1;
      else                                          stallCnt_r <= stallCnt_r;
      if (flush_e && (flushCnt_r != 32'hFFFF_FFFF)) flushCnt_r <= flushCnt_r + 32'd1;
      else                                          flushCnt_r <= flushCnt_r;
    end
  end

  assign stall_cnt = stallCnt_r;
  assign flush_cnt = flushCnt_r;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Self-checking bench for hazard_ctrl_sb: directed scenarios plus randomized cycles vs a timeline model.
module tb_hazard_ctrl_sb;

  localparam int NREG = 16;
  localparam int AW = 4;
  localparam int NSRC = 3;
  localparam int LONG_LAT = 4;
  localparam logic [AW-1:0] PC = 4'd15;
`ifdef HZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic [NSRC*AW-1:0] src_d, src_e;
  logic [NSRC-1:0] src_vld_d, src_vld_e;
  logic [AW-1:0] dst_d, dst_e, dst_m, dst_w;
  logic wr_d, long_d, pcsrc_d, wr_e, load_e, long_e, pc_cancel_e, branch_taken_e, wr_m, wr_w;
  logic [NSRC*2-1:0] fwd_e;
  logic stall_f, stall_d, flush_d, flush_e, long_busy;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_ctrl_sb #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .LONG_LAT(LONG_LAT)) dut (
    .clk(clk), .reset(reset),
    .src_d(src_d), .src_vld_d(src_vld_d), .dst_d(dst_d), .wr_d(wr_d), .long_d(long_d), .pcsrc_d(pcsrc_d),
    .src_e(src_e), .src_vld_e(src_vld_e), .dst_e(dst_e), .wr_e(wr_e), .load_e(load_e), .long_e(long_e),
    .pc_cancel_e(pc_cancel_e), .branch_taken_e(branch_taken_e),
    .dst_m(dst_m), .wr_m(wr_m), .dst_w(dst_w), .wr_w(wr_w),
    .fwd_e(fwd_e), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .long_busy(long_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index, cycle at which each register becomes readable,
  // and the pipeline age (1=E, 2=M, 3=W) of each in-flight PC writer.
  int cyc = 0;
  int readyAt [NREG];
  int pcAge [$];
  logic [31:0] mStallCnt, mFlushCnt;

  logic [NSRC*2-1:0] expFwd;
  logic expStallF, expStallD, expFlushD, expFlushE, expLongBusy;
  logic [31:0] expStallCnt, expFlushCnt;

  function automatic logic regBusy(input logic [AW-1:0] r);
    return (r != PC) && (cyc < readyAt[r]);
  endfunction

  task automatic modelReset();
    for (int r = 0; r < NREG; r++) readyAt[r] = 0;
    pcAge.delete();
    mStallCnt = 32'd0;
    mFlushCnt = 32'd0;
  endtask

  task automatic evalModel();
    logic [AW-1:0] s;
    logic luse, sb, hz, pcPend, inE, inM, inW, anyBusy;
    expFwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      s = src_e[i*AW +: AW];
      if (src_vld_e[i] && s != PC) begin
        if (wr_m && dst_m == s) expFwd[2*i +: 2] = 2'b10;
        else if (wr_w && dst_w == s) expFwd[2*i +: 2] = 2'b01;
      end
    end
    luse = 1'b0; sb = 1'b0; anyBusy = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_vld_d[i]) begin
        if (src_d[i*AW +: AW] == dst_e) luse = 1'b1;
        if (regBusy(src_d[i*AW +: AW])) sb = 1'b1;
      end
    end
    luse = luse && (load_e || long_e) && wr_e;
    for (int r = 0; r < NREG; r++) if (regBusy(AW'(r))) anyBusy = 1'b1;
    if (wr_d && regBusy(dst_d)) sb = 1'b1;
    if (long_d && anyBusy) sb = 1'b1;
    inE = 1'b0; inM = 1'b0; inW = 1'b0;
    foreach (pcAge[k]) begin
      if (pcAge[k] == 1) inE = 1'b1;
      if (pcAge[k] == 2) inM = 1'b1;
      if (pcAge[k] == 3) inW = 1'b1;
    end
    hz = luse || sb;
    pcPend = pcsrc_d || inE || inM;
    expStallD = hz && !branch_taken_e;
    expStallF = (hz || pcPend) && !branch_taken_e;
    expFlushE = hz || branch_taken_e;
    expFlushD = pcPend || inW || branch_taken_e;
    expLongBusy = anyBusy;
    expStallCnt = PERF ? mStallCnt : 32'd0;
    expFlushCnt = PERF ? mFlushCnt : 32'd0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic commitModel();
    int nq [$];
    if (expStallD) mStallCnt = mStallCnt + 32'd1;
    if (expFlushE) mFlushCnt = mFlushCnt + 32'd1;
    if (long_e && wr_e && dst_e != PC) readyAt[dst_e] = cyc + LONG_LAT;
    foreach (pcAge[k]) begin
      if (!(pcAge[k] == 1 && pc_cancel_e) && pcAge[k] < 3) nq.push_back(pcAge[k] + 1);
    end
    if (pcsrc_d && !expFlushE) nq.push_back(1);
    pcAge = nq;
    cyc++;
  endtask

  task automatic zeroInputs();
    src_d = '0; src_vld_d = '0; dst_d = '0; wr_d = 1'b0; long_d = 1'b0; pcsrc_d = 1'b0;
    src_e = '0; src_vld_e = '0; dst_e = '0; wr_e = 1'b0; load_e = 1'b0; long_e = 1'b0;
    pc_cancel_e = 1'b0; branch_taken_e = 1'b0; dst_m = '0; wr_m = 1'b0; dst_w = '0; wr_w = 1'b0;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b1;
    zeroInputs();
    #1 evalModel();
    commitModel();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    zeroInputs();
    #1 modelReset();
    evalModel();
    checks++;
    if ({stall_f, stall_d, flush_d, flush_e, long_busy} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {stall_f, stall_d, flush_d, flush_e, long_busy});
    end
    checks++;
    if (fwd_e !== 6'b000000) begin errors++; $display("FAIL reset_fwd got=%b exp=000000", fwd_e); end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    pcsrc_d = 1'b1;
    #1 evalModel();
    checks++;
    if ({stall_f, stall_d, flush_d} !== {expStallF, expStallD, expFlushD} || {stall_f, flush_d} !== 2'b11) begin
      errors++; $display("FAIL reset_pcsrc got=%b exp=%b", {stall_f, stall_d, flush_d}, {expStallF, expStallD, expFlushD});
    end
    pcsrc_d = 1'b0;
    releaseReset();
  endtask

  task automatic test_forwarding();
    logic [1:0] want [3];
    want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      zeroInputs();
      wr_m = (k != 1); dst_m = 4'd3; wr_w = 1'b1; dst_w = 4'd3;
      src_e[3:0] = (k == 2) ? 4'd15 : 4'd3;
      src_vld_e[0] = 1'b1;
      #1 evalModel();
      checks++;
      if (fwd_e[1:0] !== want[k] || fwd_e !== expFwd) begin
        errors++; $display("FAIL fwd_step%0d got=%b exp=%b", k, fwd_e, expFwd);
      end
      commitModel();
    end
  endtask

  task automatic test_load_use();
    int nStall = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      zeroInputs();
      if (k == 0) begin load_e = 1'b1; wr_e = 1'b1; dst_e = 4'd5; end
      src_d[7:4] = 4'd5; src_vld_d[1] = 1'b1;
      #1 evalModel();
      if (k == 0) begin
        checks++;
        if ({stall_f, stall_d, flush_e} !== 3'b111) begin
          errors++; $display("FAIL load_use_hit got=%b exp=111", {stall_f, stall_d, flush_e});
        end
      end
      nStall += int'(stall_d);
      commitModel();
    end
    checks++;
    if (nStall != 1) begin errors++; $display("FAIL load_use_len got=%0d exp=1", nStall); end
  endtask

  task automatic test_long_op();
    int nStall = 0;
    int fallCyc = -1;
    @(negedge clk);
    zeroInputs();
    long_e = 1'b1; wr_e = 1'b1; dst_e = 4'd7;
    #1 evalModel();
    commitModel();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      zeroInputs();
      src_d[3:0] = 4'd7; src_vld_d[0] = 1'b1;
      #1 evalModel();
      checks++;
      if (stall_d !== expStallD) begin errors++; $display("FAIL long_stall k=%0d got=%b exp=%b", k, stall_d, expStallD); end
      nStall += int'(stall_d);
      if (!long_busy && fallCyc < 0) fallCyc = k;
      commitModel();
    end
    checks++;
    if (nStall != 3) begin errors++; $display("FAIL long_stall_len got=%0d exp=3", nStall); end
    checks++;
    if (fallCyc != 4) begin errors++; $display("FAIL long_busy_fall got=%0d exp=4", fallCyc); end
  endtask

  task automatic test_waw();
    int nStall = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      zeroInputs();
      if (k == 0) begin long_e = 1'b1; wr_e = 1'b1; dst_e = 4'd7; end
      if (k == 1) begin wr_d = 1'b1; dst_d = 4'd7; end
      #1 evalModel();
      if (k == 1) begin
        checks++;
        if (stall_d !== 1'b1) begin errors++; $display("FAIL waw_stall got=%b exp=1", stall_d); end
      end
      commitModel();
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      zeroInputs();
      if (k == 0) begin long_e = 1'b1; wr_e = 1'b1; dst_e = 4'd2; end
      else begin long_d = 1'b1; wr_d = 1'b1; dst_d = 4'd9; end
      #1 evalModel();
      nStall += int'(stall_d);
      commitModel();
    end
    checks++;
    if (nStall != 3) begin errors++; $display("FAIL second_long_len got=%0d exp=3", nStall); end
  endtask

  task automatic test_pc_write(input logic cancel);
    int nStallF = 0;
    int nFlushD = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      zeroInputs();
      pcsrc_d = (k == 0);
      pc_cancel_e = cancel && (k == 1);
      #1 evalModel();
      checks++;
      if (flush_d !== expFlushD) begin errors++; $display("FAIL pc_flush_d k=%0d got=%b exp=%b", k, flush_d, expFlushD); end
      nStallF += int'(stall_f);
      nFlushD += int'(flush_d);
      commitModel();
    end
    checks++;
    if (nStallF != (cancel ? 2 : 3) || nFlushD != (cancel ? 2 : 4)) begin
      errors++; $display("FAIL pc_len cancel=%0b got=%0d/%0d exp=%0d/%0d", cancel, nStallF, nFlushD,
                         cancel ? 2 : 3, cancel ? 2 : 4);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    zeroInputs();
    load_e = 1'b1; wr_e = 1'b1; dst_e = 4'd5;
    src_d[7:4] = 4'd5; src_vld_d[1] = 1'b1;
    branch_taken_e = 1'b1;
    #1 evalModel();
    checks++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      errors++; $display("FAIL branch_priority got=%b exp=0011", {stall_f, stall_d, flush_d, flush_e});
    end
    commitModel();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      zeroInputs();
      if (k == 0) begin long_e = 1'b1; wr_e = 1'b1; dst_e = 4'd2; end
      #1 evalModel();
      commitModel();
    end
    @(negedge clk);
    zeroInputs();
    #1 evalModel();
    checks++;
    if (long_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", long_busy); end
    reset = 1'b0;
    #1 modelReset();
    evalModel();
    checks++;
    if (long_busy !== 1'b0 || expLongBusy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_busy got=%b exp=0", long_busy);
    end
    releaseReset();
    @(negedge clk);
    zeroInputs();
    #1 evalModel();
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_after_reset got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    commitModel();
    @(negedge clk);
    load_e = 1'b1; wr_e = 1'b1; dst_e = 4'd5; src_d[7:4] = 4'd5; src_vld_d[1] = 1'b1;
    #1 evalModel();
    commitModel();
    @(negedge clk);
    zeroInputs();
    #1 evalModel();
    checks++;
    if (stall_cnt !== (PERF ? 32'd1 : 32'd0) || stall_cnt !== expStallCnt) begin
      errors++; $display("FAIL perf_one_stall got=%0d exp=%0d", stall_cnt, expStallCnt);
    end
    commitModel();
  endtask

  function automatic logic [AW-1:0] rreg();
    return ($urandom_range(0, 7) == 0) ? PC : AW'($urandom_range(0, 6));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      for (int i = 0; i < NSRC; i++) begin
        src_d[i*AW +: AW] = rreg();
        src_e[i*AW +: AW] = rreg();
      end
      src_vld_d = NSRC'($urandom_range(0, 7));
      src_vld_e = NSRC'($urandom_range(0, 7));
      dst_d = rreg(); dst_e = rreg(); dst_m = rreg(); dst_w = rreg();
      wr_d = ($urandom_range(0, 1) == 1); wr_e = ($urandom_range(0, 3) != 0);
      wr_m = ($urandom_range(0, 1) == 1); wr_w = ($urandom_range(0, 1) == 1);
      long_d = ($urandom_range(0, 5) == 0); long_e = ($urandom_range(0, 5) == 0);
      load_e = ($urandom_range(0, 4) == 0); pcsrc_d = ($urandom_range(0, 6) == 0);
      pc_cancel_e = ($urandom_range(0, 2) == 0); branch_taken_e = ($urandom_range(0, 9) == 0);
      #1 evalModel();
      checks++;
      if (fwd_e !== expFwd) begin errors++; $display("FAIL rnd_fwd n=%0d got=%b exp=%b", n, fwd_e, expFwd); end
      checks++;
      if ({stall_f, stall_d} !== {expStallF, expStallD}) begin
        errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, {stall_f, stall_d}, {expStallF, expStallD});
      end
      checks++;
      if ({flush_d, flush_e} !== {expFlushD, expFlushE}) begin
        errors++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, {flush_d, flush_e}, {expFlushD, expFlushE});
      end
      checks++;
      if (long_busy !== expLongBusy) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, long_busy, expLongBusy); end
      checks++;
      if (stall_cnt !== expStallCnt || flush_cnt !== expFlushCnt) begin
        errors++; $display("FAIL rnd_perf n=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cnt, flush_cnt, expStallCnt, expFlushCnt);
      end
      commitModel();
    end
  endtask

  initial begin
    zeroInputs();
    modelReset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_long_op();
    test_waw();
    test_pc_write(1'b0);
    test_pc_write(1'b1);
    test_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
- Parametrised successor of the pipeline hazard unit for the 5-stage ARM core (F/D/E/M/W).
- Adds N source ports, register count as a parameter, and a per-register scoreboard for one long-latency unit (MUL/DIV) of configurable latency.
- Tracks PC-writing instructions internally through E/M/W instead of taking per-stage PCSrc inputs.
- Sits beside controller and datapath; drives forwarding muxes, stall and flush controls.

Parameters:
- NREG, 16: architectural registers; index NREG-1 is the PC and is never forwarded or scoreboarded.
- AW, 4: register index width, equal to clog2(NREG).
- NSRC, 3: source operands per instruction.
- LONG_LAT, 4: cycles from long-op issue in E until its result is readable from the RF; range 2..15.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- src_d  in  NSRC*AW  D-stage source register indices.
- src_vld_d  in  NSRC  D-stage source valid bits.
- dst_d  in  AW  D-stage destination index.
- wr_d  in  1  D-stage writes dst_d.
- long_d  in  1  D-stage instruction is a long op.
- pcsrc_d  in  1  D-stage instruction may write PC.
- src_e  in  NSRC*AW  E-stage source indices.
- src_vld_e  in  NSRC  E-stage source valid bits.
- dst_e  in  AW  E-stage destination.
- wr_e  in  1  E-stage register write.
- load_e  in  1  E-stage is a load (MemToRegE).
- long_e  in  1  E-stage is a long op.
- pc_cancel_e  in  1  E-stage PC write suppressed (condition failed).
- branch_taken_e  in  1  branch resolved taken in E.
- dst_m  in  AW  M-stage destination.
- wr_m  in  1  M-stage register write.
- dst_w  in  AW  W-stage destination.
- wr_w  in  1  W-stage register write.
- fwd_e  out  NSRC*2  per-source select: 00 RF, 01 W result, 10 M ALU result.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold the D register.
- flush_d  out  1  clear the D register.
- flush_e  out  1  clear the E register.
- long_busy  out  1  a long op is in flight.
- stall_cnt  out  32  stall-cycle counter (optional feature).
- flush_cnt  out  32  flush-cycle counter (optional feature).

Behaviour:
- Forwarding (combinational), per source i:
  - 10 if src_vld_e[i] & wr_m & dst_m==src_e[i] & src_e[i]!=NREG-1.
  - Otherwise 01 for the same match on the W stage.
  - Otherwise 00.
  - M has priority over W.
- Load/long-use hazard: luse = (load_e|long_e) & wr_e & (some src_vld_d[i] with src_d[i]==dst_e).
- Scoreboard: a 4-bit counter pend[r] for each r < NREG-1.
  - Issue: on long_e & wr_e & dst_e!=NREG-1, pend[dst_e] <= LONG_LAT-1 at the clock edge.
  - Every other nonzero counter decrements by 1 each cycle, independent of stalls.
  - Issue overrides decrement on the same index.
  - A count of 0 means the value is readable from the RF (write-first register file).
- sbstall = any valid source with pend!=0 | (wr_d & pend[dst_d]!=0) [WAW] | (long_d & long_busy) [single long unit].
- long_busy = OR of all pend!=0.
- PC-write tracking (registers): pcE, pcM, pcW.
  - pcE <= pcsrc_d & ~flush_e.
  - pcM <= pcE & ~pc_cancel_e.
  - pcW <= pcM.
  - pcpend = pcsrc_d | pcE | pcM.
- Stall and flush equations, with hz = luse | sbstall:
  - stall_d = hz & ~branch_taken_e.
  - stall_f = (hz | pcpend) & ~branch_taken_e.
  - flush_e = hz | branch_taken_e.
  - flush_d = pcpend | pcW | branch_taken_e.
- Simultaneous events:
  - branch_taken_e with hz: branch wins; stalls are 0, flush_d=flush_e=1.
  - Issue and decrement on the same cycle: counters for other indices still decrement.
- Reset (asynchronous, active-low): all pend=0 and pcE/pcM/pcW=0, hence:
  - stall_f/stall_d/flush_d/flush_e driven purely by inputs.
  - long_busy=0.
  - stall_cnt=flush_cnt=0.
- A reset asserted mid-operation abandons the in-flight long op.

Optional Feature:
- HZ_PERF_EN defined:
  - stall_cnt increments on each cycle with stall_d=1.
  - flush_cnt increments on each cycle with flush_e=1.
  - Both saturate at 2^32-1 and are cleared by reset.
- HZ_PERF_EN undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - PEND_W=4.
  - The pend_t typedef.
- Sub-module hazard_scoreboard holds the pend[] counters, issue/decrement logic, per-source busy lookup and long_busy.
- Top-level keeps forwarding, PC tracking, stall/flush equations and the perf counters.

Test Plan:
- Forwarding: wr_m=1, dst_m=3, wr_w=1, dst_w=3, src_e[0]=3 valid -> fwd_e[1:0]=10. Then wr_m=0 -> 01. Then src_e[0]=15 -> 00.
- Load-use: load_e=1, wr_e=1, dst_e=5, src_d[1]=5 valid -> stall_f=stall_d=flush_e=1 for exactly one cycle.
- Long op, LONG_LAT=4: long_e, dst_e=7 issued; dependent on r7 in D next cycle -> stall_d high 3 cycles. long_busy falls with the final counter decrement.
- WAW and second long op: while pend[7]!=0, wr_d dst_d=7 -> stall. long_d on another register -> stall until long_busy=0.
- PC write: pcsrc_d pulse, no cancel -> stall_f high 3 cycles, flush_d high 4 cycles. Same pulse with pc_cancel_e during the E cycle -> stall_f 2 cycles, flush_d 2 cycles.
- Priority and reset: branch_taken_e with luse -> stall_d=0, flush_d=flush_e=1. Reset asserted with pend[2]=2 -> long_busy=0 immediately. With HZ_PERF_EN, counters read 0 after reset and stall_cnt=1 after one load-use stall.
